// File: rtl/harq_comb_pkg.sv
// Shared types and saturating-add helper for the HARQ soft combiner.
// sat_add clips symmetrically to +/-(2**(w-1)-1), so the most negative code is never stored.
package harq_comb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ACC_W   = 10;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -ACC_MAX;

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] s;
    logic signed [31:0] mx;
    s  = a + b;
    mx = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (s > mx)  return mx;
    if (s < -mx) return -mx;
    return s;
  endfunction

endpackage

// File: rtl/dualport_sram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port (1-cycle latency).
// A read of the row being written in the same cycle returns the old contents.
module DualPort_SRAM #(
  parameter int DW = 160,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/harq_comb_lane.sv
// One lane of the combiner: sign-extend the LLR, then overwrite or saturate-accumulate.
// Purely combinational; timing is owned by the top-level pipeline register.
module harq_comb_lane
  import harq_comb_pkg::*;
#(
  parameter int LLR_W = 6,
  parameter int ACC_W = 10
) (
  input  logic [LLR_W-1:0] llr,
  input  logic [ACC_W-1:0] mem,
  input  logic             first,
  output logic [ACC_W-1:0] res
);

  logic signed [31:0] x;
  logic signed [31:0] m;

  assign x = {{(32 - LLR_W){llr[LLR_W-1]}}, llr};
  assign m = {{(32 - ACC_W){mem[ACC_W-1]}}, mem};

  assign res = first ? ACC_W'(x) : ACC_W'(sat_add(x, m, ACC_W));

endmodule

// File: rtl/harq_soft_combiner.sv
// HARQ soft combiner: LLR beats accumulate into the active half of a ping-pong buffer.
// Read-modify-write over 2 cycles, 1 beat/cycle, no backpressure; idle half readable at 1-cycle latency.
module harq_soft_combiner
  import harq_comb_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int LLR_W     = 6,
  parameter int ACC_W     = 10,
  parameter int ADDR_W    = 11,
  parameter int NUM_USERS = 8,
  parameter int NCB_W     = 16
) (
  input  logic                         i_core_clk,
  input  logic                         i_rx_rstn,
  input  logic                         i_rx_fsm_rstn,
  input  logic                         i_req,
  input  logic [$clog2(NUM_USERS)-1:0] i_user_idx,
  input  logic                         i_ndi,
  input  logic [NUM_USERS*NCB_W-1:0]   i_users_ncb,
  input  logic                         i_send_done,
  input  logic                         i_llr_valid,
  input  logic [LANES*LLR_W-1:0]       i_llr_data,
  input  logic                         i_llr_last,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err_ncb0,
  output logic                         o_buf_sel,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic [LANES*ACC_W-1:0]       o_rd_data
);

  localparam int LOG_L = $clog2(LANES);
  localparam int DW    = LANES * ACC_W;

  state_t              state;
  logic                busy, done, err_ncb0, buf_sel;
  logic [ADDR_W-1:0]   addr, last, last_calc;
  logic                ndi_q, lap0;
  logic [NCB_W-1:0]    ncb;
  logic [31:0]         rows_full;
  logic                beat_acc;

  logic                s1_vld, s1_first, fwd_q, rd_sel_q;
  logic [ADDR_W-1:0]   s1_addr;
  logic [LANES*LLR_W-1:0] s1_llr;
  logic [DW-1:0]       fwd_dat, wr_dat, mem_row, ping_q, pong_q, m_row;
  logic                wr_en;

  assign ncb       = i_users_ncb[32'(i_user_idx) * NCB_W +: NCB_W];
  assign rows_full = (32'(ncb) + 32'(LANES - 1)) >> LOG_L;
  assign last_calc = (rows_full > 32'(2**ADDR_W)) ? '1 : ADDR_W'(rows_full - 32'd1);
  assign beat_acc  = (state == STREAM) && i_llr_valid;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_ncb0 <= 1'b0;
      buf_sel  <= 1'b0;
      addr     <= '0;
      last     <= '0;
      ndi_q    <= 1'b0;
      lap0     <= 1'b0;
    end else if (!i_rx_fsm_rstn) begin
      // soft reset keeps buf_sel so the send-out side keeps its buffer
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_ncb0 <= 1'b0;
      addr     <= '0;
    end else begin
      err_ncb0 <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            if (ncb == '0) begin
              err_ncb0 <= 1'b1;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
              last  <= last_calc;
              ndi_q <= i_ndi;
              addr  <= '0;
              lap0  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (i_send_done) state <= STREAM;
        end
        STREAM: begin
          if (i_llr_valid) begin
            addr <= (addr == last) ? '0 : addr + 1'b1;
            if (addr == last) lap0 <= 1'b0;
            if (i_llr_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          buf_sel <= ~buf_sel;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      s1_vld   <= 1'b0;
      fwd_q    <= 1'b0;
      rd_sel_q <= 1'b1;
    end else begin
      s1_vld   <= beat_acc & i_rx_fsm_rstn;
      // the RAM read for this beat misses the write landing on the same edge
      fwd_q    <= beat_acc & s1_vld & (s1_addr == addr);
      rd_sel_q <= ~buf_sel;
    end
  end

  always_ff @(posedge i_core_clk) begin
    s1_addr  <= addr;
    s1_llr   <= i_llr_data;
    s1_first <= lap0 & ndi_q;
    fwd_dat  <= wr_dat;
  end

  assign mem_row = buf_sel ? pong_q : ping_q;
  assign m_row   = fwd_q ? fwd_dat : mem_row;
  assign wr_en   = s1_vld & i_rx_fsm_rstn;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    harq_comb_lane #(
      .LLR_W(LLR_W),
      .ACC_W(ACC_W)
    ) u_lane (
      .llr  (s1_llr[j*LLR_W +: LLR_W]),
      .mem  (m_row[j*ACC_W +: ACC_W]),
      .first(s1_first),
      .res  (wr_dat[j*ACC_W +: ACC_W])
    );
  end

  DualPort_SRAM #(
    .DW(DW),
    .AW(ADDR_W)
  ) u_ping (
    .clk    (i_core_clk),
    .wr_en  (wr_en & ~buf_sel),
    .wr_addr(s1_addr),
    .wr_data(wr_dat),
    .rd_addr(buf_sel ? i_rd_addr : addr),
    .rd_data(ping_q)
  );

  DualPort_SRAM #(
    .DW(DW),
    .AW(ADDR_W)
  ) u_pong (
    .clk    (i_core_clk),
    .wr_en  (wr_en & buf_sel),
    .wr_addr(s1_addr),
    .wr_data(wr_dat),
    .rd_addr(buf_sel ? addr : i_rd_addr),
    .rd_data(pong_q)
  );

  assign o_busy     = busy;
  assign o_done     = done;
  assign o_err_ncb0 = err_ncb0;
  assign o_buf_sel  = buf_sel;
  assign o_rd_data  = rd_sel_q ? pong_q : ping_q;

endmodule

// File: tb/tb_harq_soft_combiner.sv
// Scoreboard bench for harq_soft_combiner: a per-lane model of both buffers predicts read-back rows.
module tb_harq_soft_combiner;

  localparam int LANES = 16, LLR_W = 6, ACC_W = 10, ADDR_W = 11;
  localparam int NUM_USERS = 8, NCB_W = 16;
  localparam int DW = LANES * ACC_W;
  localparam int AMAX = 511;
  localparam int DEPTH = 2048;

  logic clk = 1'b0, rstn = 1'b0, fsm_rstn = 1'b1;
  logic req = 1'b0, ndi = 1'b0, send_done = 1'b0;
  logic llr_valid = 1'b0, llr_last = 1'b0;
  logic [2:0] user_idx = '0;
  logic [NUM_USERS*NCB_W-1:0] users_ncb;
  logic [LANES*LLR_W-1:0] llr_data = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic busy, done, err_ncb0, buf_sel;
  logic [DW-1:0] rd_data;

  int n_chk = 0, n_err = 0;
  int mdl[2][DEPTH][LANES];
  int ncb_tab[NUM_USERS] = '{64, 16, 0, 20, 65535, 64, 64, 64};
  logic exp_sel = 1'b0;
  int cur_rows, cur_n;
  bit cur_ndi;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  harq_soft_combiner dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_rx_fsm_rstn(fsm_rstn),
    .i_req(req), .i_user_idx(user_idx), .i_ndi(ndi), .i_users_ncb(users_ncb),
    .i_send_done(send_done), .i_llr_valid(llr_valid), .i_llr_data(llr_data),
    .i_llr_last(llr_last), .o_busy(busy), .o_done(done), .o_err_ncb0(err_ncb0),
    .o_buf_sel(buf_sel), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clip(input int v);
    if (v > AMAX) return AMAX;
    if (v < -AMAX) return -AMAX;
    return v;
  endfunction

  function automatic logic [DW-1:0] pack(input int b, input int r);
    logic [DW-1:0] v;
    int t;
    for (int j = 0; j < LANES; j++) begin
      t = mdl[b][r][j];
      v[j*ACC_W +: ACC_W] = t[ACC_W-1:0];
    end
    return v;
  endfunction

  // Walks IDLE -> WAIT -> STREAM; junk beats offered while WAIT must be ignored.
  task automatic start_req(input int user, input bit nd, input int wait_cyc);
    int c;
    c = (ncb_tab[user] + LANES - 1) / LANES;
    cur_rows = (c > DEPTH) ? DEPTH : c;
    cur_ndi = nd;
    cur_n = 0;
    @(negedge clk);
    req = 1'b1; user_idx = user[2:0]; ndi = nd; send_done = (wait_cyc > 0);
    @(negedge clk);
    req = 1'b0; send_done = 1'b0;
    chk("busy_wait", DW'(busy), DW'(1));
    for (int k = 0; k < wait_cyc; k++) begin
      llr_valid = 1'b1;
      llr_data = {$urandom, $urandom, $urandom};
      @(negedge clk);
    end
    if (wait_cyc > 0) chk("busy_held", DW'(busy), DW'(1));
    llr_valid = 1'b0; send_done = 1'b1;
    @(negedge clk);
    send_done = 1'b0;
  endtask

  // mode 0: every lane = base; mode 1: random LLR per lane. Beat stop_at carries a soft reset.
  task automatic send_beats(input int nb, input int mode, input int base,
                            input int stop_at, input bit last_en);
    logic [LANES*LLR_W-1:0] d;
    int v, row, lap;
    for (int n = 0; n < nb; n++) begin
      row = cur_n % cur_rows;
      lap = cur_n / cur_rows;
      for (int j = 0; j < LANES; j++) begin
        v = (mode != 0) ? int'($urandom_range(63)) - 32 : base;
        d[j*LLR_W +: LLR_W] = v[LLR_W-1:0];
        if (stop_at < 0 || n < stop_at - 1)
          mdl[exp_sel][row][j] = (lap == 0 && cur_ndi) ? v : clip(v + mdl[exp_sel][row][j]);
      end
      llr_valid = 1'b1; llr_data = d;
      llr_last = last_en && (n == nb - 1);
      if (n == stop_at) fsm_rstn = 1'b0;
      cur_n++;
      @(negedge clk);
      if (n == stop_at) break;
    end
    llr_valid = 1'b0; llr_last = 1'b0; fsm_rstn = 1'b1;
  endtask

  task automatic finish_req();
    int dcnt;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("done_once", DW'(dcnt), DW'(1));
    exp_sel = ~exp_sel;
    chk("buf_sel_flip", DW'(buf_sel), DW'(exp_sel));
    chk("busy_idle", DW'(busy), DW'(0));
  endtask

  task automatic read_rows(input int b, input int n);
    for (int r = 0; r <= n; r++) begin
      if (r > 0) chk($sformatf("rd_b%0d_r%0d", b, r - 1), rd_data, exp_q.pop_front());
      if (r < n) begin
        rd_addr = r[ADDR_W-1:0];
        exp_q.push_back(pack(b, r));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int t;
    for (int k = 0; k < NUM_USERS; k++) begin
      t = ncb_tab[k];
      users_ncb[k*NCB_W +: NCB_W] = t[NCB_W-1:0];
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_err", DW'(err_ncb0), DW'(0));
    chk("rst_buf_sel", DW'(buf_sel), DW'(0));

    // first-lap fill, then a second lap that combines
    start_req(0, 1'b1, 0); send_beats(4, 0, 5, -1, 1'b1); finish_req(); read_rows(0, 4);
    start_req(0, 1'b1, 0); send_beats(8, 0, 5, -1, 1'b1); finish_req(); read_rows(1, 4);

    // prefill +500 / -500 through single-row laps, then saturate on retransmission
    start_req(1, 1'b1, 0); send_beats(16, 0, 31, -1, 1'b0); send_beats(1, 0, 4, -1, 1'b1);
    finish_req(); read_rows(0, 1);
    start_req(1, 1'b1, 0); send_beats(15, 0, -32, -1, 1'b0); send_beats(1, 0, -20, -1, 1'b1);
    finish_req(); read_rows(1, 1);
    start_req(1, 1'b0, 0); send_beats(1, 0, 31, -1, 1'b1); finish_req(); read_rows(0, 1);
    start_req(1, 1'b0, 0); send_beats(1, 0, -32, -1, 1'b1); finish_req(); read_rows(1, 1);

    // rows==1, back-to-back beats
    start_req(1, 1'b1, 0); send_beats(3, 0, 1, -1, 1'b1); finish_req(); read_rows(0, 1);

    // Ncb==0 rejected
    @(negedge clk); req = 1'b1; user_idx = 3'd2;
    @(negedge clk); req = 1'b0;
    chk("err_pulse", DW'(err_ncb0), DW'(1));
    chk("err_busy", DW'(busy), DW'(0));
    @(negedge clk);
    chk("err_clear", DW'(err_ncb0), DW'(0));

    // WAIT held without send_done; random retransmission combine
    start_req(0, 1'b0, 4); send_beats(4, 1, 0, -1, 1'b1); finish_req(); read_rows(1, 4);

    // soft reset on beat 2: only beat 0 reaches RAM, buf_sel unchanged
    start_req(0, 1'b1, 0); send_beats(4, 0, 7, 2, 1'b1);
    chk("srst_busy", DW'(busy), DW'(0));
    chk("srst_buf_sel", DW'(buf_sel), DW'(exp_sel));
    start_req(1, 1'b0, 0); send_beats(1, 0, 2, -1, 1'b1); finish_req(); read_rows(0, 4);

    // Ncb not a multiple of LANES, random data across three laps
    start_req(3, 1'b1, 0); send_beats(5, 1, 0, -1, 1'b1); finish_req(); read_rows(1, 2);

    // row count capped at buffer depth: beat 2048 wraps onto row 0
    start_req(4, 1'b1, 0); send_beats(DEPTH + 1, 0, 1, -1, 1'b1); finish_req(); read_rows(0, 3);

    // async reset mid-STREAM clears buf_sel
    start_req(0, 1'b1, 0); send_beats(1, 0, 3, -1, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst_buf_sel", DW'(buf_sel), DW'(0));
    chk("arst_busy", DW'(busy), DW'(0));
    exp_sel = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    read_rows(1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
